// File: rtl/seg_pattern_reader.sv
// Seven-segment bus snooper: recovers per-digit hex values from the multiplexed active-low lines.
// Optional decimal-point capture is enabled by defining SEG_READER_DP_EN.
module seg_pattern_reader #(
  parameter int NUM_DIGITS    = 8,
  parameter int IDX_W         = 3,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_en,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg_n,
`ifdef SEG_READER_DP_EN
  input  logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   dp_on,
`endif
  input  logic                    clr_err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    upd_pulse,
  output logic [IDX_W-1:0]        upd_idx,
  output logic                    bad_pattern
);

`ifdef SEG_READER_DP_EN
  localparam int SW = NUM_DIGITS + 8;
`else
  localparam int SW = NUM_DIGITS + 7;
`endif
  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  // Returns {is_hex, is_blank, value} for a segment pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    case (s)
      7'b0000001: decode_seg = {2'b10, 4'h0};
      7'b1001111: decode_seg = {2'b10, 4'h1};
      7'b0010010: decode_seg = {2'b10, 4'h2};
      7'b0000110: decode_seg = {2'b10, 4'h3};
      7'b1001100: decode_seg = {2'b10, 4'h4};
      7'b0100100: decode_seg = {2'b10, 4'h5};
      7'b0100000: decode_seg = {2'b10, 4'h6};
      7'b0001111: decode_seg = {2'b10, 4'h7};
      7'b0000000: decode_seg = {2'b10, 4'h8};
      7'b0000100: decode_seg = {2'b10, 4'h9};
      7'b0001000: decode_seg = {2'b10, 4'hA};
      7'b1100000: decode_seg = {2'b10, 4'hB};
      7'b0110001: decode_seg = {2'b10, 4'hC};
      7'b1000010: decode_seg = {2'b10, 4'hD};
      7'b0110000: decode_seg = {2'b10, 4'hE};
      7'b0111000: decode_seg = {2'b10, 4'hF};
      7'b1111111: decode_seg = {2'b01, 4'h0};
      default:    decode_seg = {2'b00, 4'h0};
    endcase
  endfunction

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [SW-1:0]           last_r, last_s, sample_s;
  logic [4*NUM_DIGITS-1:0] digits_r, digits_s;
  logic [NUM_DIGITS-1:0]   valid_r, valid_s, blank_r, blank_s, onehot_s;
  logic                    pulse_r, pulse_s, bad_r, bad_s, commit_s, sel_valid_s;
  logic [IDX_W-1:0]        idx_r, idx_out_s, idx_s;
  logic [5:0]              dec_s;
`ifdef SEG_READER_DP_EN
  logic [NUM_DIGITS-1:0]   dp_r, dp_s;
  assign sample_s = {dp_n, an_n, seg_n};
`else
  assign sample_s = {an_n, seg_n};
`endif

  assign dec_s = decode_seg(seg_n);

  // Select validity (exactly one low bit) and the position of that bit.
  always_comb begin
    onehot_s    = ~an_n;
    sel_valid_s = (onehot_s != {NUM_DIGITS{1'b0}}) &&
                  ((onehot_s & (onehot_s - NUM_DIGITS'(1'b1))) == {NUM_DIGITS{1'b0}});
    idx_s = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_n[i]) begin
        idx_s = IDX_W'(i);
      end else begin
        idx_s = idx_s;
      end
    end
  end

  // Stability FSM next state and commit decision.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    last_s   = last_r;
    commit_s = 1'b0;
    if (sample_en) begin
      last_s = sample_s;
      case (state_r)
        IDLE: begin
          if (sel_valid_s) begin
            state_s = TRACK;
            cnt_s   = CNT_W'(1'b1);
          end else begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
          end
        end
        TRACK: begin
          if (!sel_valid_s) begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
          end else if (sample_s == last_r) begin
            cnt_s = cnt_r + CNT_W'(1'b1);
          end else begin
            cnt_s = CNT_W'(1'b1);
          end
        end
        HELD: begin
          if (!sel_valid_s) begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
          end else if (sample_s != last_r) begin
            state_s = TRACK;
            cnt_s   = CNT_W'(1'b1);
          end else begin
            state_s = HELD;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end
      endcase
      // A run reaching the threshold commits this cycle; covers the single-sample case too.
      if ((state_s == TRACK) && (cnt_s == STABLE_CNT)) begin
        commit_s = 1'b1;
        state_s  = HELD;
      end else begin
        commit_s = 1'b0;
      end
    end else begin
      last_s = last_r;
    end
  end

  // Shadow register file updates on commit; bad-set beats clear.
  always_comb begin
    digits_s  = digits_r;
    valid_s   = valid_r;
    blank_s   = blank_r;
    idx_out_s = idx_r;
    pulse_s   = commit_s;
    bad_s     = bad_r & ~clr_err;
`ifdef SEG_READER_DP_EN
    dp_s      = dp_r;
`endif
    if (commit_s) begin
      idx_out_s = idx_s;
      if (!dec_s[5] && !dec_s[4]) begin
        bad_s = 1'b1;
      end else begin
        bad_s = bad_s;
      end
    end else begin
      idx_out_s = idx_r;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (commit_s && (IDX_W'(i) == idx_s)) begin
`ifdef SEG_READER_DP_EN
        dp_s[i] = ~dp_n;
`endif
        if (dec_s[5]) begin
          digits_s[4*i +: 4] = dec_s[3:0];
          valid_s[i]         = 1'b1;
          blank_s[i]         = 1'b0;
        end else if (dec_s[4]) begin
          valid_s[i] = 1'b0;
          blank_s[i] = 1'b1;
        end else begin
          valid_s[i] = valid_r[i];
        end
      end else begin
        valid_s[i] = valid_r[i];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      last_r   <= {SW{1'b1}};
      digits_r <= {(4*NUM_DIGITS){1'b0}};
      valid_r  <= {NUM_DIGITS{1'b0}};
      blank_r  <= {NUM_DIGITS{1'b1}};
      pulse_r  <= 1'b0;
      idx_r    <= {IDX_W{1'b0}};
      bad_r    <= 1'b0;
`ifdef SEG_READER_DP_EN
      dp_r     <= {NUM_DIGITS{1'b0}};
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      last_r   <= last_s;
      digits_r <= digits_s;
      valid_r  <= valid_s;
      blank_r  <= blank_s;
      pulse_r  <= pulse_s;
      idx_r    <= idx_out_s;
      bad_r    <= bad_s;
`ifdef SEG_READER_DP_EN
      dp_r     <= dp_s;
`endif
    end
  end

  assign digits      = digits_r;
  assign digit_valid = valid_r;
  assign blank       = blank_r;
  assign upd_pulse   = pulse_r;
  assign upd_idx     = idx_r;
  assign bad_pattern = bad_r;
`ifdef SEG_READER_DP_EN
  assign dp_on       = dp_r;
`endif

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Directed, table-driven bench for seg_pattern_reader with hand-computed expectations.
module tb_seg_pattern_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_en;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        clr_err;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic [7:0]  blank;
  logic        upd_pulse;
  logic [2:0]  upd_idx;
  logic        bad_pattern;
`ifdef SEG_READER_DP_EN
  logic        dp_n = 1'b1;
  logic [7:0]  dp_on;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  seg_pattern_reader dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .an_n(an_n), .seg_n(seg_n),
`ifdef SEG_READER_DP_EN
    .dp_n(dp_n), .dp_on(dp_on),
`endif
    .clr_err(clr_err), .digits(digits), .digit_valid(digit_valid), .blank(blank),
    .upd_pulse(upd_pulse), .upd_idx(upd_idx), .bad_pattern(bad_pattern)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        clr;
    int          reps;
    int          pulse_at;
    logic        chk;
    logic [31:0] dig;
    logic [7:0]  val;
    logic [7:0]  blk;
    logic        bad;
    logic [2:0]  idx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic [7:0] an, logic [6:0] seg, logic clr, int reps,
                              int pulse_at, logic chk, logic [31:0] dig, logic [7:0] val,
                              logic [7:0] blk, logic bad, logic [2:0] idx);
    vec_t v;
    v.en = en; v.an = an; v.seg = seg; v.clr = clr; v.reps = reps; v.pulse_at = pulse_at;
    v.chk = chk; v.dig = dig; v.val = val; v.blk = blk; v.bad = bad; v.idx = idx;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] dig, input logic [7:0] val,
                               input logic [7:0] blk, input logic bad, input logic [2:0] idx,
                               input logic pulse);
    check({tag, ".digits"}, digits, dig);
    check({tag, ".valid"}, {24'd0, digit_valid}, {24'd0, val});
    check({tag, ".blank"}, {24'd0, blank}, {24'd0, blk});
    check({tag, ".bad"}, {31'd0, bad_pattern}, {31'd0, bad});
    check({tag, ".idx"}, {29'd0, upd_idx}, {29'd0, idx});
    check({tag, ".pulse"}, {31'd0, upd_pulse}, {31'd0, pulse});
  endtask

  task automatic drive(input logic en, input logic [7:0] an, input logic [6:0] seg, input logic clr);
    sample_en = en;
    an_n      = an;
    seg_n     = seg;
    clr_err   = clr;
  endtask

  initial begin
    // en an seg clr reps pulse_at chk digits valid blank bad idx
    tbl.push_back(mk(1'b1, 8'hFE, 7'b0000110, 1'b0, 4, 4, 1'b1, 32'h00000003, 8'h01, 8'hFE, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 8'hFE, 7'b0000110, 1'b0, 20, 0, 1'b1, 32'h00000003, 8'h01, 8'hFE, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 8'hFE, 7'b0001000, 1'b0, 5, 4, 1'b1, 32'h0000000A, 8'h01, 8'hFE, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 8'hFD, 7'b1100000, 1'b0, 5, 4, 1'b1, 32'h000000BA, 8'h03, 8'hFC, 1'b0, 3'd1));
    tbl.push_back(mk(1'b1, 8'hFB, 7'b0110001, 1'b0, 5, 4, 1'b1, 32'h00000CBA, 8'h07, 8'hF8, 1'b0, 3'd2));
    tbl.push_back(mk(1'b1, 8'hF7, 7'b1000010, 1'b0, 5, 4, 1'b1, 32'h0000DCBA, 8'h0F, 8'hF0, 1'b0, 3'd3));
    tbl.push_back(mk(1'b1, 8'hEF, 7'b0110000, 1'b0, 5, 4, 1'b1, 32'h000EDCBA, 8'h1F, 8'hE0, 1'b0, 3'd4));
    tbl.push_back(mk(1'b1, 8'hDF, 7'b0111000, 1'b0, 5, 4, 1'b1, 32'h00FEDCBA, 8'h3F, 8'hC0, 1'b0, 3'd5));
    tbl.push_back(mk(1'b1, 8'hBF, 7'b0000001, 1'b0, 5, 4, 1'b1, 32'h00FEDCBA, 8'h7F, 8'h80, 1'b0, 3'd6));
    tbl.push_back(mk(1'b1, 8'h7F, 7'b0000100, 1'b0, 5, 4, 1'b1, 32'h90FEDCBA, 8'hFF, 8'h00, 1'b0, 3'd7));
    // short run then a different pattern: only the second run commits
    tbl.push_back(mk(1'b1, 8'hFB, 7'b0001000, 1'b0, 3, 0, 1'b0, 32'h0, 8'h0, 8'h0, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 8'hFB, 7'b0000000, 1'b0, 4, 4, 1'b1, 32'h90FED8BA, 8'hFF, 8'h00, 1'b0, 3'd2));
    // unqualified cycles in the middle of a run freeze the count
    tbl.push_back(mk(1'b1, 8'hF7, 7'b0000110, 1'b0, 2, 0, 1'b0, 32'h0, 8'h0, 8'h0, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, 8'h00, 7'b1010101, 1'b0, 5, 0, 1'b0, 32'h0, 8'h0, 8'h0, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 8'hF7, 7'b0000110, 1'b0, 2, 2, 1'b1, 32'h90FE38BA, 8'hFF, 8'h00, 1'b0, 3'd3));
    // blank commit, then bad commits with clear interplay
    tbl.push_back(mk(1'b1, 8'hEF, 7'b1111111, 1'b0, 4, 4, 1'b1, 32'h90FE38BA, 8'hEF, 8'h10, 1'b0, 3'd4));
    tbl.push_back(mk(1'b1, 8'hDF, 7'b1111110, 1'b0, 4, 4, 1'b1, 32'h90FE38BA, 8'hEF, 8'h10, 1'b1, 3'd5));
    tbl.push_back(mk(1'b1, 8'hBF, 7'b1111110, 1'b0, 3, 0, 1'b0, 32'h0, 8'h0, 8'h0, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 8'hBF, 7'b1111110, 1'b1, 1, 1, 1'b1, 32'h90FE38BA, 8'hEF, 8'h10, 1'b1, 3'd6));
    tbl.push_back(mk(1'b1, 8'hBF, 7'b1111110, 1'b1, 1, 0, 1'b1, 32'h90FE38BA, 8'hEF, 8'h10, 1'b0, 3'd6));
    // invalid selects never commit
    tbl.push_back(mk(1'b1, 8'hF3, 7'b0000110, 1'b0, 10, 0, 1'b1, 32'h90FE38BA, 8'hEF, 8'h10, 1'b0, 3'd6));
    tbl.push_back(mk(1'b1, 8'hFF, 7'b0000110, 1'b0, 3, 0, 1'b1, 32'h90FE38BA, 8'hEF, 8'h10, 1'b0, 3'd6));

    rst_n = 1'b0;
    drive(1'b1, 8'hFF, 7'b1111111, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 32'h0, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      for (int k = 1; k <= tbl[r].reps; k++) begin
        drive(tbl[r].en, tbl[r].an, tbl[r].seg, tbl[r].clr);
        @(posedge clk);
        #1;
        check($sformatf("row%0d.rep%0d.pulse", r, k), {31'd0, upd_pulse},
              {31'd0, (k == tbl[r].pulse_at)});
      end
      if (tbl[r].chk) begin
        check_outputs($sformatf("row%0d", r), tbl[r].dig, tbl[r].val, tbl[r].blk,
                      tbl[r].bad, tbl[r].idx, upd_pulse);
      end
    end

    // Mid-run reset: three samples of a run, reset, then one more sample must not commit.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 8'hFD, 7'b0000110, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("prerst%0d.pulse", k), {31'd0, upd_pulse}, 32'd0);
    end
    rst_n = 1'b0;
    #1;
    check_outputs("midrst", 32'h0, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("postrst", 32'h0, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("newrun%0d.pulse", k), {31'd0, upd_pulse}, {31'd0, (k == 4)});
    end
    check_outputs("newrun", 32'h00000030, 8'h02, 8'hFD, 1'b0, 3'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
